// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic-light display driver.
// Phase codes, lamp bit positions, seven-segment patterns, saturation limit.
package traffic_pkg;

   // Sequencer phase codes as delivered on the phase input.
   typedef enum logic [1:0] {
      PH_OFF     = 2'b00,
      PH_LEFT    = 2'b01,
      PH_FORWARD = 2'b10,
      PH_RIGHT   = 2'b11
   } phase_e;

   // Binary-to-BCD converter states.
   typedef enum logic [1:0] {
      CONV_IDLE  = 2'b00,
      CONV_SHIFT = 2'b01,
      CONV_LOAD  = 2'b10
   } conv_state_e;

   // Lamp bus is {red, right, forward, left}.
   localparam int LAMP_LEFT    = 0;
   localparam int LAMP_FORWARD = 1;
   localparam int LAMP_RIGHT   = 2;
   localparam int LAMP_RED     = 3;

   // Displayed count never exceeds two decimal digits.
   localparam int SAT_LIMIT = 99;

   // Active-low segment patterns {g..a} for decimal digits 0..9.
   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DIGITS [0:9] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Non-decimal codes cannot occur, but map them to a dark digit anyway.
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      if (digit <= 4'd9) begin
         return SEG_DIGITS[digit];
      end
      return SEG_BLANK;
   endfunction

   // One-hot lamp for a phase; OFF shows red as the safe state.
   function automatic logic [3:0] lamp_decode(input phase_e ph);
      logic [3:0] lamp_v;
      lamp_v = '0;
      case (ph)
         PH_OFF:     lamp_v[LAMP_RED]     = 1'b1;
         PH_LEFT:    lamp_v[LAMP_LEFT]    = 1'b1;
         PH_FORWARD: lamp_v[LAMP_FORWARD] = 1'b1;
         PH_RIGHT:   lamp_v[LAMP_RIGHT]   = 1'b1;
         default:    lamp_v[LAMP_RED]     = 1'b1;
      endcase
      return lamp_v;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-add-3 converter, 7-bit binary to two BCD digits.
// start_i is honoured only in IDLE; done_o pulses for the single LOAD cycle,
// during which tens_o/ones_o hold the finished result.
module bin2bcd_seq
   import traffic_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [6:0] bin_i,
   output logic       busy_o,
   output logic       done_o,
   output logic [3:0] tens_o,
   output logic [3:0] ones_o
);

   conv_state_e state_q, state_d;
   logic [6:0]  shreg_q, shreg_d;
   logic [7:0]  bcd_q, bcd_d;
   logic [2:0]  iter_q, iter_d;
   logic [7:0]  bcd_adj;

   // Add-3 correction for every BCD nibble that would overflow when doubled.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_adj
         assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                     bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
      end
   endgenerate

   // State and scratch registers; reset discards any partial conversion.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= CONV_IDLE;
         shreg_q <= '0;
         bcd_q   <= '0;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bcd_q   <= bcd_d;
         iter_q  <= iter_d;
      end
   end

   // Next state: latch on start, seven MSB-first shift iterations, one load cycle.
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bcd_d   = bcd_q;
      iter_d  = iter_q;
      done_o  = 1'b0;
      busy_o  = (state_q != CONV_IDLE);
      case (state_q)
         CONV_IDLE: begin
            if (start_i) begin
               shreg_d = bin_i;
               bcd_d   = '0;
               iter_d  = '0;
               state_d = CONV_SHIFT;
            end
         end
         CONV_SHIFT: begin
            {bcd_d, shreg_d} = {bcd_adj, shreg_q} << 1;
            iter_d = iter_q + 3'd1;
            if (iter_q == 3'd6) begin
               state_d = CONV_LOAD;
            end
         end
         CONV_LOAD: begin
            done_o  = 1'b1;
            state_d = CONV_IDLE;
         end
         default: state_d = CONV_IDLE;
      endcase
   end

   assign tens_o = bcd_q[7:4];
   assign ones_o = bcd_q[3:0];

endmodule

// File: rtl/traffic_display_driver.sv
// traffic_display_driver: lamps plus 2-digit multiplexed countdown display.
// Optional build macro TRAFFIC_DISP_BLINK_EN: blink the active lamp while the
// displayed count is 1..3 (red never blinks). Without it lamps are steady.
module traffic_display_driver
   import traffic_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  phase,
   input  logic [31:0] count,
   output logic [3:0]  lamp,
   output logic [6:0]  seg,
   output logic [1:0]  an,
   output logic        bcd_valid
);

   // Dividers below 2 cannot produce a wrap; stop elaboration.
   generate
      if (SCAN_DIV < 2 || BLINK_DIV < 2) begin : g_param_check
         $error("traffic_display_driver: SCAN_DIV and BLINK_DIV must be >= 2");
      end
   endgenerate

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

   phase_e            phase_q;
   logic [31:0]       count_q;
   logic              cap_valid_q;
   logic [6:0]        sat;
   logic [6:0]        conv_bin_q;
   logic [6:0]        disp_bin_q;
   logic [3:0]        disp_tens_q, disp_ones_q;
   logic              conv_start, conv_busy, conv_done;
   logic [3:0]        conv_tens, conv_ones;
   logic [SCAN_W-1:0] scan_cnt_q;
   logic              sel_q;
   logic [6:0]        seg_q;
   logic [1:0]        an_q;
   logic [3:0]        lamp_q;
   logic              lamp_dark;

   // Input capture; cap_valid_q holds bcd_valid low until the first capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q     <= PH_OFF;
         count_q     <= '0;
         cap_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_e'(phase);
         count_q     <= count;
         cap_valid_q <= 1'b1;
      end
   end

   assign sat        = (count_q > 32'(SAT_LIMIT)) ? 7'(SAT_LIMIT) : count_q[6:0];
   assign conv_start = !conv_busy && (sat != disp_bin_q);
   assign bcd_valid  = cap_valid_q && !conv_busy && (disp_bin_q == sat);

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .reset   (reset),
      .start_i (conv_start),
      .bin_i   (sat),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .tens_o  (conv_tens),
      .ones_o  (conv_ones)
   );

   // Remember the value under conversion and publish it with its digits on done.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         conv_bin_q  <= '0;
         disp_bin_q  <= '0;
         disp_tens_q <= '0;
         disp_ones_q <= '0;
      end else begin
         if (conv_start) begin
            conv_bin_q <= sat;
         end
         if (conv_done) begin
            disp_bin_q  <= conv_bin_q;
            disp_tens_q <= conv_tens;
            disp_ones_q <= conv_ones;
         end
      end
   end

   // Multiplex timer: digit select flips each time the counter wraps.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_cnt_q <= '0;
         sel_q      <= 1'b0;
      end else if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_q <= '0;
         sel_q      <= ~sel_q;
      end else begin
         scan_cnt_q <= scan_cnt_q + SCAN_W'(1);
      end
   end

   // Registered digit drive; a leading-zero tens digit is dark but still enabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seg_q <= SEG_BLANK;
         an_q  <= 2'b11;
      end else if (!sel_q) begin
         seg_q <= seg_encode(disp_ones_q);
         an_q  <= 2'b10;
      end else begin
         seg_q <= (disp_tens_q == 4'd0) ? SEG_BLANK : seg_encode(disp_tens_q);
         an_q  <= 2'b01;
      end
   end

`ifdef TRAFFIC_DISP_BLINK_EN
   localparam int BLINK_W = $clog2(BLINK_DIV);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

   logic [BLINK_W-1:0] blink_cnt_q;
   logic               blink_on_q;
   logic               blink_cond;

   assign blink_cond = (phase_q != PH_OFF) && (disp_bin_q >= 7'd1) && (disp_bin_q <= 7'd3);

   // Blink timer parks at 0/on outside the final seconds so each entry starts lit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (!blink_cond) begin
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
      end else if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_q <= '0;
         blink_on_q  <= ~blink_on_q;
      end else begin
         blink_cnt_q <= blink_cnt_q + BLINK_W'(1);
      end
   end

   assign lamp_dark = blink_cond && !blink_on_q;
`else
   assign lamp_dark = 1'b0;
`endif

   // Lamp output register: second stage of the phase-to-lamp path.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lamp_q <= 4'b1000;
      end else begin
         lamp_q <= lamp_dark ? 4'b0000 : lamp_decode(phase_q);
      end
   end

   assign lamp = lamp_q;
   assign seg  = seg_q;
   assign an   = an_q;

endmodule

// File: tb/tb_traffic_display_driver.sv
// Directed bench for traffic_display_driver with SCAN_DIV=4, BLINK_DIV=4.
module tb_traffic_display_driver;

   localparam int SCAN  = 4;
   localparam int BLINK = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  phase;
   logic [31:0] count;
   logic [3:0]  lamp;
   logic [6:0]  seg;
   logic [1:0]  an;
   logic        bcd_valid;

   int checks = 0;
   int errors = 0;
   int an_bad = 0;

   traffic_display_driver #(
      .SCAN_DIV  (SCAN),
      .BLINK_DIV (BLINK)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .phase     (phase),
      .count     (count),
      .lamp      (lamp),
      .seg       (seg),
      .an        (an),
      .bcd_valid (bcd_valid)
   );

   always #5 clk = ~clk;

   // Both anodes low would light both digits at once.
   always @(negedge clk) begin
      if (reset === 1'b0 && an === 2'b00) an_bad++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_valid(input string tag);
      int k;
      k = 0;
      while (bcd_valid !== 1'b1 && k < 30) begin
         tick(1);
         k++;
      end
      check(tag, {31'd0, bcd_valid}, 32'd1);
   endtask

   task automatic read_digits(output logic [6:0] ones, output logic [6:0] tens);
      ones = 'x;
      tens = 'x;
      for (int i = 0; i < 2*SCAN + 2; i++) begin
         tick(1);
         if (an == 2'b10) ones = seg;
         else if (an == 2'b01) tens = seg;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] s_ones, s_tens;
      logic [1:0] an_ref;
      int k;

      reset = 1'b1;
      phase = 2'b00;
      count = 32'd0;
      tick(2);
      check("rst_lamp", {28'd0, lamp}, 32'h8);
      check("rst_seg", {25'd0, seg}, 32'h7F);
      check("rst_an", {30'd0, an}, 32'h3);
      check("rst_valid", {31'd0, bcd_valid}, 32'd0);
      $display("txn reset: lamp=%b seg=%h an=%b valid=%b", lamp, seg, an, bcd_valid);

      reset = 1'b0;
      tick(2);
      check("post_rst_valid", {31'd0, bcd_valid}, 32'd1);
      check("post_rst_lamp", {28'd0, lamp}, 32'h8);

      // count 0 -> 15, FORWARD: lamp after 2 edges, digits after 10 edges
      count = 32'd15;
      phase = 2'b10;
      tick(1);
      check("c15_valid_e1", {31'd0, bcd_valid}, 32'd0);
      check("c15_lamp_e1", {28'd0, lamp}, 32'h8);
      tick(1);
      check("c15_lamp_e2", {28'd0, lamp}, 32'h2);
      tick(7);
      check("c15_valid_e9", {31'd0, bcd_valid}, 32'd0);
      tick(1);
      check("c15_valid_e10", {31'd0, bcd_valid}, 32'd1);
      read_digits(s_ones, s_tens);
      check("c15_ones", {25'd0, s_ones}, 32'h12);
      check("c15_tens", {25'd0, s_tens}, 32'h79);
      $display("txn count=15 phase=FWD: ones=%h tens=%h lamp=%b", s_ones, s_tens, lamp);

      // saturation
      count = 32'd250;
      tick(2);
      wait_valid("c250_valid");
      read_digits(s_ones, s_tens);
      check("c250_ones", {25'd0, s_ones}, 32'h10);
      check("c250_tens", {25'd0, s_tens}, 32'h10);
      $display("txn count=250: ones=%h tens=%h", s_ones, s_tens);

      // leading-zero blanking
      count = 32'd7;
      tick(2);
      wait_valid("c7_valid");
      read_digits(s_ones, s_tens);
      check("c7_ones", {25'd0, s_ones}, 32'h78);
      check("c7_tens", {25'd0, s_tens}, 32'h7F);
      $display("txn count=7: ones=%h tens=%h", s_ones, s_tens);

      // change 15 -> 14 during SHIFT: 15 completes at edge 10, 14 at edge 19
      count = 32'd15;
      tick(4);
      count = 32'd14;
      tick(6);
      check("chg_valid_e10", {31'd0, bcd_valid}, 32'd0);
      tick(8);
      check("chg_valid_e18", {31'd0, bcd_valid}, 32'd0);
      tick(1);
      check("chg_valid_e19", {31'd0, bcd_valid}, 32'd1);
      read_digits(s_ones, s_tens);
      check("chg_ones", {25'd0, s_ones}, 32'h19);
      check("chg_tens", {25'd0, s_tens}, 32'h79);
      $display("txn count=15->14 mid-shift: ones=%h tens=%h valid=%b", s_ones, s_tens, bcd_valid);

      // scan cadence: anodes alternate 10/01, each held for SCAN cycles
      an_ref = an;
      k = 0;
      while (an == an_ref && k < 12) begin
         tick(1);
         k++;
      end
      check("scan_legal", {31'd0, (an == 2'b10 || an == 2'b01)}, 32'd1);
      an_ref = an;
      for (int r = 0; r < 3; r++) begin
         for (int j = 0; j < SCAN - 1; j++) begin
            tick(1);
            check("scan_hold", {30'd0, an}, {30'd0, an_ref});
         end
         an_ref = an_ref ^ 2'b11;
         tick(1);
         check("scan_toggle", {30'd0, an}, {30'd0, an_ref});
      end
      $display("txn scan: three %0d-cycle digit slots observed, last an=%b", SCAN, an);

      // final seconds: LEFT with count 3
      phase = 2'b01;
      count = 32'd3;
      tick(2);
      wait_valid("c3_valid");
`ifdef TRAFFIC_DISP_BLINK_EN
      k = 0;
      while (lamp !== 4'b0000 && k < 12) begin
         tick(1);
         k++;
      end
      check("blink_dark_found", {28'd0, lamp}, 32'h0);
      for (int j = 0; j < BLINK - 1; j++) begin
         tick(1);
         check("blink_dark_hold", {28'd0, lamp}, 32'h0);
      end
      for (int j = 0; j < BLINK; j++) begin
         tick(1);
         check("blink_lit", {28'd0, lamp}, 32'h1);
      end
      tick(1);
      check("blink_dark_again", {28'd0, lamp}, 32'h0);
      $display("txn LEFT count=3: lamp blinks with half-period %0d", BLINK);
`else
      for (int j = 0; j < 12; j++) begin
         tick(1);
         check("left_steady", {28'd0, lamp}, 32'h1);
      end
      $display("txn LEFT count=3: lamp steady %b", lamp);
`endif

      // same count with phase OFF: red never blinks
      phase = 2'b00;
      tick(2);
      for (int j = 0; j < 12; j++) begin
         tick(1);
         check("red_steady", {28'd0, lamp}, 32'h8);
      end
      $display("txn OFF count=3: lamp %b", lamp);

      // reset asserted during SHIFT iteration 4 of a 42 conversion
      phase = 2'b11;
      count = 32'd42;
      tick(5);
      check("pre_rst_lamp", {28'd0, lamp}, 32'h4);
      #2 reset = 1'b1;
      #1;
      check("midrst_lamp", {28'd0, lamp}, 32'h8);
      check("midrst_seg", {25'd0, seg}, 32'h7F);
      check("midrst_an", {30'd0, an}, 32'h3);
      check("midrst_valid", {31'd0, bcd_valid}, 32'd0);
      $display("txn reset mid-conversion: lamp=%b seg=%h an=%b valid=%b", lamp, seg, an, bcd_valid);
      tick(2);
      reset = 1'b0;
      tick(2);
      wait_valid("c42_valid");
      read_digits(s_ones, s_tens);
      check("c42_ones", {25'd0, s_ones}, 32'h24);
      check("c42_tens", {25'd0, s_tens}, 32'h19);
      check("c42_lamp", {28'd0, lamp}, 32'h4);
      $display("txn count=42 after reset: ones=%h tens=%h", s_ones, s_tens);

      check("an_never_both", an_bad, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
